// File: rtl/riscv_pkg.sv
// Register map, TIMER_CTRL bit positions and byte-lane write helpers shared by
// the MMIO GPIO/timer peripheral and the firmware headers generated from it.
package riscv_pkg;

    localparam logic [7:0] REG_GPIO_OUT    = 8'h00;
    localparam logic [7:0] REG_GPIO_IN     = 8'h04;
    localparam logic [7:0] REG_GPIO_EDGE   = 8'h08;
    localparam logic [7:0] REG_TIMER_CTRL  = 8'h0C;
    localparam logic [7:0] REG_TIMER_LOAD  = 8'h10;
    localparam logic [7:0] REG_TIMER_COUNT = 8'h14;
    localparam logic [7:0] REG_STATUS      = 8'h18;
    localparam logic [7:0] REG_CYCLE       = 8'h1C;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_TIRQ_EN = 2;
    localparam int CTRL_EIRQ_EN = 3;
    localparam int CTRL_BITS    = 4;

    function automatic logic [31:0] byte_mask(input logic [3:0] wen);
        logic [31:0] mask;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{wen[k]}};
        end
        return mask;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wen);
        logic [31:0] mask;
        mask = byte_mask(wen);
        return (old_val & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/mmio_gpio_timer_input_debouncer.sv
// Input path: 2-flop synchroniser, shared sample prescaler and a 3-sample
// agreement filter per bit, with a rising-edge pulse on each debounced 0->1.
module input_debouncer #(
    parameter int IN_WIDTH = 16,
    parameter int DEB_DIV  = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] din_i,
    output logic [IN_WIDTH-1:0] deb_o,
    output logic [IN_WIDTH-1:0] rise_o
);
    localparam int PW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

    logic [IN_WIDTH-1:0]      sync1_q, sync2_q;
    logic [PW-1:0]            pre_q, pre_d;
    logic                     tick;
    logic [IN_WIDTH-1:0]      deb_q, deb_d;
    logic [IN_WIDTH-1:0][1:0] cnt_q, cnt_d;

    assign tick = (pre_q == PW'(DEB_DIV - 1));

    // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (tick) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (cnt_q[i] == 2'd2) begin
                        deb_d[i] = sync2_q[i];
                        cnt_d[i] = 2'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 2'd1;
                    end
                end else begin
                    cnt_d[i] = 2'd0;
                end
            end
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pre_q   <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o  = deb_q;
    // Combinational so the edge flag sets on the same edge the debounced value rises.
    assign rise_o = deb_d & ~deb_q;

endmodule

// File: rtl/mmio_gpio_timer.sv
// MMIO GPIO/timer peripheral: byte-strobed register file, debounced inputs with
// sticky edges, down-counting timer with interrupt, cycle counter, registered read.
module mmio_gpio_timer
    import riscv_pkg::*;
#(
    parameter int OUT_WIDTH   = 16,
    parameter int IN_WIDTH    = 16,
    parameter int DEB_DIV     = 1000,
    parameter int TIMER_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_mmio_enable,
    input  logic [7:0]           i_mmio_addr,
    input  logic [3:0]           i_mmio_wen,
    input  logic [31:0]          i_mmio_data_in,
    output logic [31:0]          o_mmio_data_out,
    output logic [OUT_WIDTH-1:0] gpio_out,
    input  logic [IN_WIDTH-1:0]  gpio_in,
    output logic                 o_irq
);
    logic [IN_WIDTH-1:0]    deb_in, deb_rise;
    logic [OUT_WIDTH-1:0]   gpio_out_q, gpio_out_d;
    logic [IN_WIDTH-1:0]    edge_q, edge_d, edge_clr;
    logic [CTRL_BITS-1:0]   ctrl_q, ctrl_d, ctrl_new;
    logic [TIMER_WIDTH-1:0] load_q, load_d, load_new, count_q, count_d;
    logic                   expired_q, expired_d, irq_q, irq_d;
    logic [31:0]            cycle_q, cycle_d, rdata_q, rdata_d, wmask;
    logic [7:0]             sel;
    logic                   wr_en, rd_en, step, expire;
    logic                   gpio_wr, edge_wr, ctrl_wr, load_wr, status_wr;

    input_debouncer #(.IN_WIDTH(IN_WIDTH), .DEB_DIV(DEB_DIV)) u_debouncer (
        .clk    (clk),
        .reset  (reset),
        .din_i  (gpio_in),
        .deb_o  (deb_in),
        .rise_o (deb_rise)
    );

    assign sel       = i_mmio_addr & 8'hFC;
    assign wr_en     = i_mmio_enable && (i_mmio_wen != 4'b0000);
    assign rd_en     = i_mmio_enable && (i_mmio_wen == 4'b0000);
    assign wmask     = byte_mask(i_mmio_wen);
    assign gpio_wr   = wr_en && (sel == REG_GPIO_OUT);
    assign edge_wr   = wr_en && (sel == REG_GPIO_EDGE);
    assign ctrl_wr   = wr_en && (sel == REG_TIMER_CTRL);
    assign load_wr   = wr_en && (sel == REG_TIMER_LOAD);
    assign status_wr = wr_en && (sel == REG_STATUS);
    assign ctrl_new  = CTRL_BITS'(byte_merge(32'(ctrl_q), i_mmio_data_in, i_mmio_wen));
    assign load_new  = TIMER_WIDTH'(byte_merge(32'(load_q), i_mmio_data_in, i_mmio_wen));
    assign edge_clr  = edge_wr ? IN_WIDTH'(i_mmio_data_in & wmask) : '0;

    // A CTRL write clearing EN stops the timer in the very cycle of the write.
    assign step   = ctrl_q[CTRL_EN] && !(ctrl_wr && !ctrl_new[CTRL_EN]);
    assign expire = step && (count_q == '0);

    always_comb begin
        gpio_out_d = gpio_wr ? OUT_WIDTH'(byte_merge(32'(gpio_out_q), i_mmio_data_in, i_mmio_wen))
                             : gpio_out_q;
        edge_d     = (edge_q & ~edge_clr) | deb_rise;
        expired_d  = (expired_q && !(status_wr && wmask[0] && i_mmio_data_in[0])) || expire;
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        count_d    = count_q;
        if (step) begin
            if (count_q != '0)          count_d = count_q - 1'b1;
            else if (ctrl_q[CTRL_AUTO]) count_d = load_q;
            else                        ctrl_d[CTRL_EN] = 1'b0;
        end
        // Bus writes override timer-driven updates to the same registers.
        if (ctrl_wr) ctrl_d = ctrl_new;
        if (load_wr) begin
            load_d  = load_new;
            count_d = load_new;
        end
        cycle_d = cycle_q + 32'd1;
        irq_d   = (ctrl_q[CTRL_TIRQ_EN] && expired_q) || (ctrl_q[CTRL_EIRQ_EN] && (|edge_q));
        rdata_d = '0;
        if (rd_en) begin
            case (sel)
                REG_GPIO_OUT:    rdata_d = 32'(gpio_out_q);
                REG_GPIO_IN:     rdata_d = 32'(deb_in);
                REG_GPIO_EDGE:   rdata_d = 32'(edge_q);
                REG_TIMER_CTRL:  rdata_d = 32'(ctrl_q);
                REG_TIMER_LOAD:  rdata_d = 32'(load_q);
                REG_TIMER_COUNT: rdata_d = 32'(count_q);
                REG_STATUS:      rdata_d = {31'd0, expired_q};
                REG_CYCLE:       rdata_d = cycle_q;
                default:         rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out_q <= '0;
            edge_q     <= '0;
            ctrl_q     <= '0;
            load_q     <= '0;
            count_q    <= '0;
            expired_q  <= 1'b0;
            cycle_q    <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            edge_q     <= edge_d;
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            cycle_q    <= cycle_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
        end
    end

    assign gpio_out        = gpio_out_q;
    assign o_mmio_data_out = rdata_q;
    assign o_irq           = irq_q;

endmodule

// File: tb/tb_mmio_gpio_timer.sv
// Self-checking bench for mmio_gpio_timer: randomized bus/input stimulus checked
// against expectations computed from the register-level behaviour.
module tb_mmio_gpio_timer;
    localparam int OW = 16;
    localparam int IW = 16;
    localparam int DD = 4;
    localparam int TW = 32;

    localparam logic [7:0] A_OUT = 8'h00, A_IN = 8'h04, A_EDGE = 8'h08, A_CTRL = 8'h0C;
    localparam logic [7:0] A_LOAD = 8'h10, A_COUNT = 8'h14, A_STATUS = 8'h18, A_CYCLE = 8'h1C;

    logic          clk, reset, i_mmio_enable, o_irq;
    logic [7:0]    i_mmio_addr;
    logic [3:0]    i_mmio_wen;
    logic [31:0]   i_mmio_data_in, o_mmio_data_out;
    logic [OW-1:0] gpio_out;
    logic [IW-1:0] gpio_in;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned edge_no  = 0;

    mmio_gpio_timer #(.OUT_WIDTH(OW), .IN_WIDTH(IW), .DEB_DIV(DD), .TIMER_WIDTH(TW)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_mmio_enable   (i_mmio_enable),
        .i_mmio_addr     (i_mmio_addr),
        .i_mmio_wen      (i_mmio_wen),
        .i_mmio_data_in  (i_mmio_data_in),
        .o_mmio_data_out (o_mmio_data_out),
        .gpio_out        (gpio_out),
        .gpio_in         (gpio_in),
        .o_irq           (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] w);
        i_mmio_enable = 1'b1; i_mmio_addr = a; i_mmio_data_in = d; i_mmio_wen = w;
        tick();
        i_mmio_enable = 1'b0; i_mmio_wen = 4'b0; i_mmio_data_in = '0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        i_mmio_enable = 1'b1; i_mmio_addr = a; i_mmio_wen = 4'b0;
        tick();
        d = o_mmio_data_out;
        i_mmio_enable = 1'b0;
    endtask

    function automatic logic [31:0] lane_write(input logic [31:0] old_val, input logic [31:0] d,
                                               input logic [3:0] w);
        logic [31:0] r;
        r = old_val;
        for (int k = 0; k < 4; k++) if (w[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        logic [7:0]  offs [7];
        offs = '{A_OUT, A_IN, A_EDGE, A_CTRL, A_LOAD, A_COUNT, A_STATUS};
        reset = 1'b1;
        idle(3);
        n_checks++;
        if (gpio_out !== '0 || o_irq !== 1'b0 || o_mmio_data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gpio_out=%h irq=%b rdata=%h, expected all 0",
                     gpio_out, o_irq, o_mmio_data_out);
        end
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus_read(offs[i], d);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_reg_%h: got %h, expected 0", offs[i], d);
            end
        end
        bus_read(A_CYCLE, d);
        n_checks++;
        if (d >= 32'd16) begin
            n_fail++;
            $display("FAIL reset_cycle: got %0d, expected below 16", d);
        end
    endtask

    task automatic test_gpio_out();
        logic [31:0] d, m, wd;
        logic [3:0]  w;
        logic        en;
        bus_write(A_OUT, 32'h0000_FFFF, 4'hF);
        bus_write(A_OUT, 32'h0000_A5A5, 4'b0001);
        n_checks++;
        if (gpio_out !== 16'hFFA5) begin
            n_fail++; $display("FAIL gpio_out_lane0: got %h, expected FFA5", gpio_out);
        end
        bus_read(A_OUT, d);
        n_checks++;
        if (d !== 32'h0000_FFA5) begin
            n_fail++; $display("FAIL gpio_out_read: got %h, expected 0000FFA5", d);
        end
        tick();
        n_checks++;
        if (o_mmio_data_out !== 32'h0) begin
            n_fail++; $display("FAIL rdata_idle_zero: got %h, expected 0", o_mmio_data_out);
        end
        m = 32'h0000_FFA5;
        for (int i = 0; i < 10; i++) begin
            wd = $urandom;
            w  = 4'($urandom_range(1, 15));
            en = ($urandom_range(0, 3) != 0);
            i_mmio_enable = en; i_mmio_addr = A_OUT; i_mmio_data_in = wd; i_mmio_wen = w;
            tick();
            i_mmio_enable = 1'b0; i_mmio_wen = 4'b0;
            if (en) m = lane_write(m, wd, w) & 32'h0000_FFFF;
            bus_read(A_OUT, d);
            n_checks++;
            if (gpio_out !== m[15:0] || d !== m) begin
                n_fail++;
                $display("FAIL gpio_out_rand%0d: got pins=%h read=%h, expected %h (en=%b wen=%b)",
                         i, gpio_out, d, m, en, w);
            end
        end
        bus_write(8'h20, 32'hFFFF_FFFF, 4'hF);
        n_checks++;
        if (gpio_out !== m[15:0]) begin
            n_fail++; $display("FAIL unmapped_write: got %h, expected %h", gpio_out, m[15:0]);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic [7:0]  offs [3];
        offs = '{8'h3C, 8'h20, 8'h27};
        for (int i = 0; i < 3; i++) begin
            bus_read(offs[i], d);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++; $display("FAIL unmapped_read_%h: got %h, expected 0", offs[i], d);
            end
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        int          seen;
        seen = 0;
        gpio_in[3] = 1'b1;
        for (int k = 1; k <= 30 && seen == 0; k++) begin
            bus_read(A_IN, d);
            if (d[3]) seen = k;
        end
        n_checks++;
        if (seen < 11 || seen > 16) begin
            n_fail++; $display("FAIL debounce_latency: got %0d cycles, expected 11..16", seen);
        end
        bus_read(A_EDGE, d);
        n_checks++;
        if (d !== 32'h8) begin
            n_fail++; $display("FAIL edge_set: got %h, expected 00000008", d);
        end
        gpio_in[5] = 1'b1;
        idle(3);
        gpio_in[5] = 1'b0;
        idle(30);
        bus_read(A_IN, d);
        n_checks++;
        if (d !== 32'h8) begin
            n_fail++; $display("FAIL glitch_in: got %h, expected 00000008", d);
        end
        bus_read(A_EDGE, d);
        n_checks++;
        if (d !== 32'h8) begin
            n_fail++; $display("FAIL glitch_edge: got %h, expected 00000008", d);
        end
        bus_write(A_CTRL, 32'h8, 4'b0001);
        idle(2);
        n_checks++;
        if (o_irq !== 1'b1) begin
            n_fail++; $display("FAIL edge_irq: got %b, expected 1", o_irq);
        end
        bus_write(A_EDGE, 32'h0000_0800, 4'b0010);
        bus_write(A_EDGE, 32'h0000_0008, 4'b0010);
        bus_read(A_EDGE, d);
        n_checks++;
        if (d !== 32'h8) begin
            n_fail++; $display("FAIL w1c_unstrobed: got %h, expected 00000008", d);
        end
        bus_write(A_EDGE, 32'h0000_0008, 4'b0001);
        n_checks++;
        if (o_irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_lag: got %b, expected 1", o_irq);
        end
        tick();
        n_checks++;
        if (o_irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_cleared: got %b, expected 0", o_irq);
        end
        bus_read(A_EDGE, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL edge_w1c: got %h, expected 0", d);
        end
        bus_write(A_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_random_inputs();
        logic [31:0] d, em, cur, v, msk;
        em  = '0;
        cur = 32'(gpio_in);
        for (int i = 0; i < 4; i++) begin
            v = 32'($urandom_range(0, 65535));
            em |= v & ~cur;
            cur = v;
            gpio_in = v[IW-1:0];
            idle(25);
            bus_read(A_IN, d);
            n_checks++;
            if (d !== v) begin
                n_fail++; $display("FAIL rand_in%0d: got %h, expected %h", i, d, v);
            end
            bus_read(A_EDGE, d);
            n_checks++;
            if (d !== em) begin
                n_fail++; $display("FAIL rand_edge%0d: got %h, expected %h", i, d, em);
            end
            msk = 32'($urandom_range(0, 65535));
            bus_write(A_EDGE, msk, 4'b0011);
            em &= ~msk;
        end
    endtask

    task automatic test_timer_auto_irq();
        int unsigned w0;
        logic        exp;
        bus_write(A_CTRL, 32'h0, 4'hF);
        bus_write(A_STATUS, 32'h1, 4'b0001);
        bus_write(A_LOAD, 32'd5, 4'hF);
        bus_write(A_CTRL, 32'h7, 4'b0001);
        w0 = edge_no;
        for (int j = 1; j <= 20; j++) begin
            bus_write(A_STATUS, 32'h1, 4'b0001);
            exp = (j >= 7) && ((j - 1) % 6 == 0);
            n_checks++;
            if (o_irq !== exp) begin
                n_fail++;
                $display("FAIL timer_irq_j%0d: got %b, expected %b (edge %0d after enable)",
                         j, o_irq, exp, edge_no - w0);
            end
        end
        bus_write(A_CTRL, 32'h0, 4'hF);
        bus_write(A_STATUS, 32'h1, 4'b0001);
    endtask

    task automatic test_timer_oneshot();
        logic [31:0] d;
        logic [31:0] exp [4];
        logic [7:0]  a [4];
        bus_write(A_LOAD, 32'd3, 4'hF);
        bus_write(A_CTRL, 32'h1, 4'b0001);
        idle(10);
        a   = '{A_CTRL, A_COUNT, A_STATUS, A_STATUS};
        exp = '{32'h0, 32'h0, 32'h1, 32'h0};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus_write(A_STATUS, 32'h1, 4'b0001);
                idle(8);
            end
            bus_read(a[i], d);
            n_checks++;
            if (d !== exp[i]) begin
                n_fail++; $display("FAIL oneshot_%0d_%h: got %h, expected %h", i, a[i], d, exp[i]);
            end
        end
    endtask

    task automatic test_timer_random();
        logic [31:0] d, exp;
        int unsigned w0, r, h, ld;
        for (int i = 0; i < 6; i++) begin
            ld = $urandom_range(1, 20);
            bus_write(A_LOAD, ld, 4'hF);
            bus_write(A_CTRL, 32'h3, 4'b0001);
            w0 = edge_no;
            idle($urandom_range(0, 40));
            bus_read(A_COUNT, d);
            r   = edge_no;
            exp = ld - ((r - 1 - w0) % (ld + 1));
            n_checks++;
            if (d !== exp) begin
                n_fail++; $display("FAIL timer_count%0d: got %0d, expected %0d (load %0d)", i, d, exp, ld);
            end
            bus_write(A_CTRL, 32'h0, 4'b0001);
            h   = edge_no;
            exp = ld - ((h - 1 - w0) % (ld + 1));
            idle(3);
            bus_read(A_COUNT, d);
            n_checks++;
            if (d !== exp) begin
                n_fail++; $display("FAIL timer_halt%0d: got %0d, expected %0d", i, d, exp);
            end
        end
    endtask

    task automatic test_timer_precedence();
        logic [31:0] d;
        bus_write(A_LOAD, 32'd4, 4'hF);
        bus_write(A_CTRL, 32'h3, 4'b0001);
        idle(4);
        bus_write(A_LOAD, 32'd9, 4'hF);
        bus_read(A_COUNT, d);
        n_checks++;
        if (d !== 32'd9) begin
            n_fail++; $display("FAIL load_vs_reload: got %0d, expected 9", d);
        end
        bus_read(A_COUNT, d);
        n_checks++;
        if (d !== 32'd8) begin
            n_fail++; $display("FAIL load_then_count: got %0d, expected 8", d);
        end
        bus_write(A_CTRL, 32'h0, 4'hF);
        bus_write(A_LOAD, 32'h0000_1234, 4'hF);
        bus_write(A_COUNT, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_COUNT, d);
        n_checks++;
        if (d !== 32'h0000_1234) begin
            n_fail++; $display("FAIL count_readonly: got %h, expected 00001234", d);
        end
    endtask

    task automatic test_cycle();
        logic [31:0] c1, c2;
        int          k;
        for (int i = 0; i < 3; i++) begin
            k = $urandom_range(0, 20);
            bus_read(A_CYCLE, c1);
            idle(k);
            bus_read(A_CYCLE, c2);
            n_checks++;
            if (c2 - c1 !== 32'(k + 1)) begin
                n_fail++; $display("FAIL cycle_delta%0d: got %0d, expected %0d", i, c2 - c1, k + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_write(A_OUT, 32'hFFFF, 4'hF);
        bus_write(A_STATUS, 32'h1, 4'b0001);
        bus_write(A_LOAD, 32'd2, 4'hF);
        bus_write(A_CTRL, 32'h7, 4'b0001);
        gpio_in = 16'hFFFF;
        idle(6);
        n_checks++;
        if (o_irq !== 1'b1 || gpio_out !== 16'hFFFF) begin
            n_fail++; $display("FAIL pre_reset: got irq=%b gpio=%h, expected 1 FFFF", o_irq, gpio_out);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (gpio_out !== '0 || o_irq !== 1'b0 || o_mmio_data_out !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got gpio=%h irq=%b rdata=%h, expected all 0",
                     gpio_out, o_irq, o_mmio_data_out);
        end
        idle(2);
        reset = 1'b0;
        bus_read(A_EDGE, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL post_reset_edge: got %h, expected 0", d);
        end
        bus_read(A_CYCLE, d);
        n_checks++;
        if (d >= 32'd8) begin
            n_fail++; $display("FAIL post_reset_cycle: got %0d, expected below 8", d);
        end
        bus_read(A_IN, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL post_reset_in: got %h, expected 0", d);
        end
        bus_read(A_CTRL, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL post_reset_ctrl: got %h, expected 0", d);
        end
        idle(25);
        bus_read(A_IN, d);
        n_checks++;
        if (d !== 32'hFFFF) begin
            n_fail++; $display("FAIL post_reset_in_high: got %h, expected 0000FFFF", d);
        end
        bus_read(A_EDGE, d);
        n_checks++;
        if (d !== 32'hFFFF) begin
            n_fail++; $display("FAIL post_reset_edge_high: got %h, expected 0000FFFF", d);
        end
    endtask

    initial begin
        reset = 1'b1; i_mmio_enable = 1'b0; i_mmio_addr = '0;
        i_mmio_wen = '0; i_mmio_data_in = '0; gpio_in = '0;
        test_reset();
        test_gpio_out();
        test_unmapped();
        test_debounce();
        test_random_inputs();
        test_timer_auto_irq();
        test_timer_oneshot();
        test_timer_random();
        test_timer_precedence();
        test_cycle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_gpio_timer.md
# mmio_gpio_timer

Parametrised memory-mapped peripheral on the core's MMIO port, the next generation of the board-level LED/switch register block. It adds byte-strobed writes, synchronised and debounced inputs with sticky edge capture, a programmable down-counting timer with interrupt, and a free-running cycle counter. The read data register is built in, so read latency matches the data BRAM and no external pipeline stage is needed before the read mux.

## Interface
Parameters:
- OUT_WIDTH, 16: GPIO output bits (1..32).
- IN_WIDTH, 16: GPIO input bits (1..32).
- DEB_DIV, 1000: debounce sample-tick period in clk cycles (≥2).
- TIMER_WIDTH, 32: timer counter width (8..32).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- i_mmio_enable  in  1  access strobe from the memory map decoder.
- i_mmio_addr  in  8  byte address; word index is [7:2], [1:0] ignored.
- i_mmio_wen  in  4  byte write strobes; all zero = read.
- i_mmio_data_in  in  32  write data.
- o_mmio_data_out  out  32  registered read data.
- gpio_out  out  OUT_WIDTH  registered output pins (LEDs).
- gpio_in  in  IN_WIDTH  asynchronous input pins (switches).
- o_irq  out  1  level interrupt.

## Operation
Register map (word offset, access):
- 0x00 GPIO_OUT, RW, [OUT_WIDTH-1:0]. Byte-strobed. Unused bits read 0.
- 0x04 GPIO_IN, RO. Debounced input value.
- 0x08 GPIO_EDGE, W1C. Sticky flag per bit, set on a debounced 0→1 transition.
- 0x0C TIMER_CTRL, RW.
  - bit0 EN.
  - bit1 AUTO (auto-reload).
  - bit2 TIRQ_EN (timer interrupt enable).
  - bit3 EIRQ_EN (edge interrupt enable).
- 0x10 TIMER_LOAD, RW. A write also copies the new value into TIMER_COUNT.
- 0x14 TIMER_COUNT, RO.
- 0x18 STATUS, W1C. bit0 EXPIRED.
- 0x1C CYCLE, RO. 32-bit free-running counter; wraps 0xFFFF_FFFF→0.
- Other offsets: reads return 0; writes are ignored.

Write rules:
- Byte lane k is written only if i_mmio_wen[k]=1 and i_mmio_enable=1.
- W1C registers clear only those bits written as 1 within strobed lanes.

Input path:
- Each input passes through a 2-flop synchroniser.
- A shared prescaler emits a tick every DEB_DIV cycles.
- A bit's debounced value changes only after 3 consecutive ticks sample the same new level.

Timer, evaluated on each cycle with EN=1:
- COUNT≠0: COUNT decrements.
- COUNT=0: EXPIRED is set. If AUTO=1, COUNT←LOAD. If AUTO=0, EN clears and COUNT stays 0.
- EN=1 with LOAD=0 and AUTO=1: EXPIRED is set every cycle.

Interrupt: o_irq = (TIRQ_EN & EXPIRED) | (EIRQ_EN & |GPIO_EDGE). Registered.

## Timing
- Read: enable with wen=0 at cycle N → o_mmio_data_out valid at N+1. On any cycle without a read, o_mmio_data_out is 0.
- Write: register updates at the clock edge ending cycle N and is visible to a read issued at N+1.
- gpio_out updates 1 cycle after the write cycle.
- Set wins over clear: an EXPIRED or edge event in the same cycle as its W1C leaves the flag set.
- Timer write precedence: a TIMER_LOAD write in the same cycle as an expiry reload loads the written value. A TIMER_CTRL write with EN=0 halts the counter that cycle.
- Input latency: 2 synchroniser cycles + up to 3×DEB_DIV cycles + 1 cycle to GPIO_IN/EDGE.
- o_irq follows a flag change by 1 cycle.
- Reset, including mid-operation: all registers, counters, prescaler, synchronisers, debounced values and flags → 0; gpio_out=0, o_mmio_data_out=0, o_irq=0. Inputs held high through reset produce no edge flag until the debouncer first sees them as 1 after reset.

## Structure
- Register word offsets (localparams) and the TIMER_CTRL bit positions go in riscv_pkg, so firmware headers and the top level share them.
- One sub-module: input_debouncer, parametrised by IN_WIDTH and DEB_DIV. It contains the synchroniser, prescaler and 3-sample filter, and outputs the debounced vector and a rising-edge pulse vector.
- The register file, timer, cycle counter and read mux live in the top module.

## Test plan
- Write 0x0000_A5A5 to 0x00 with wen=4'b0001 after a full 0xFFFF write → gpio_out=0xFFA5; a read at 0x00 returns 0x0000_FFA5 exactly one cycle later.
- DEB_DIV=4, gpio_in[3] 0→1 held steady → GPIO_IN[3]=1 and GPIO_EDGE[3]=1 within 2+12+1 cycles; a glitch lasting under 2 ticks → no change.
- LOAD=5, CTRL=EN|AUTO|TIRQ_EN → EXPIRED set and o_irq=1 one cycle later, every 6 cycles; W1C to STATUS in an expiry cycle → EXPIRED stays 1.
- LOAD=3, CTRL=EN with AUTO=0 → one expiry, then EN reads 0 and COUNT reads 0.
- Assert reset mid-count with gpio_out=0xFFFF and o_irq=1 → all outputs 0 next cycle; CYCLE reads small values after release.
- Read 0x3C and 0x20 → 0; write 0x14 → COUNT unaffected.
